// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - decode inputs and datapath controls between control unit and CPU datapath
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             Zero;
    logic             Sign;
    logic [2:0]       state;
    logic [2:0]       nextState;
    logic             PCWre;
    logic             IRWre;
    logic             InsMemRW;
    logic             RegWre;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic [2:0]       ALUOp;
    logic [2:0]       ExtSel;
    logic             mRD;
    logic             mWR;
    logic             DBDataSrc;
    logic             WrRegDSrc;
    logic [1:0]       PCSrc;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  op, funct3, funct7b5, Zero, Sign,
        output state, nextState, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB,
               ALUOp, ExtSel, mRD, mWR, DBDataSrc, WrRegDSrc, PCSrc, halted, instr_count
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Sign,
        input  state, nextState, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB,
               ALUOp, ExtSel, mRD, mWR, DBDataSrc, WrRegDSrc, PCSrc, halted, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - IF/ID/EXE/MEM/WB control FSM for the multi-cycle RV32I-subset CPU
module multicycle_control_unit #(
    parameter logic [6:0] HALT_OP = 7'b1111111,
    parameter int         CNT_W   = 32
) (
    input  logic                       CLK,
    input  logic                       Reset,
    multicycle_control_unit_if.master  bus
);
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t           state, next_state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    logic is_r, is_ialu, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_halt;
    assign is_r    = (bus.op == 7'b0110011);
    assign is_ialu = (bus.op == 7'b0010011);
    assign is_ld   = (bus.op == 7'b0000011);
    assign is_st   = (bus.op == 7'b0100011);
    assign is_br   = (bus.op == 7'b1100011);
    assign is_jal  = (bus.op == 7'b1101111);
    assign is_jalr = (bus.op == 7'b1100111);
    assign is_lui  = (bus.op == 7'b0110111);
    assign is_halt = (bus.op == HALT_OP);

    logic [2:0] alu_dec, ext_class;
    logic       br_taken;

    always_comb begin
        alu_dec = 3'b000;
        if (is_r || is_ialu) begin
            case (bus.funct3)
                3'b000:  alu_dec = (is_r && bus.funct7b5) ? 3'b001 : 3'b000;
                3'b010,
                3'b011:  alu_dec = 3'b010;
                3'b111:  alu_dec = 3'b011;
                3'b110:  alu_dec = 3'b100;
                3'b100:  alu_dec = 3'b101;
                3'b001:  alu_dec = 3'b110;
                default: alu_dec = 3'b111;
            endcase
        end
    end

    always_comb begin
        ext_class = 3'b000;
        if (is_st)       ext_class = 3'b001;
        else if (is_br)  ext_class = 3'b010;
        else if (is_lui) ext_class = 3'b011;
        else if (is_jal) ext_class = 3'b100;
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  br_taken = bus.Zero;
            3'b001:  br_taken = !bus.Zero;
            3'b100:  br_taken = bus.Sign;
            3'b101:  br_taken = !bus.Sign;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state    = state;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.RegWre    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.ExtSel    = (state == S_IF) ? 3'b000 : ext_class;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.WrRegDSrc = 1'b0;
        bus.PCSrc     = 2'b00;
        case (state)
            S_IF: begin
                // a halted CPU parks here with fetch disabled until reset
                if (!halted) begin
                    bus.InsMemRW = 1'b1;
                    bus.IRWre    = 1'b1;
                    next_state   = S_ID;
                end
            end
            S_ID: begin
                if (is_r || is_ialu || is_lui)  next_state = S_EXE_AL;
                else if (is_br)                 next_state = S_EXE_BR;
                else if (is_ld || is_st)        next_state = S_EXE_LS;
                else if (is_jal || is_jalr)     next_state = S_WB_AL;
                else begin
                    next_state = S_IF;
                    bus.PCWre  = !is_halt;
                end
            end
            S_EXE_AL: begin
                bus.ALUSrcB = is_ialu || is_lui;
                bus.ALUSrcA = is_lui;
                bus.ALUOp   = alu_dec;
                next_state  = S_WB_AL;
            end
            S_WB_AL: begin
                bus.RegWre = 1'b1;
                bus.PCWre  = 1'b1;
                next_state = S_IF;
                if (is_jal) begin
                    bus.WrRegDSrc = 1'b1;
                    bus.PCSrc     = 2'b01;
                end else if (is_jalr) begin
                    bus.WrRegDSrc = 1'b1;
                    bus.PCSrc     = 2'b10;
                    bus.ALUSrcB   = 1'b1;
                end else begin
                    // hold the EXE operand selects so the written result stays stable
                    bus.ALUSrcB = is_ialu || is_lui;
                    bus.ALUSrcA = is_lui;
                    bus.ALUOp   = alu_dec;
                end
            end
            S_EXE_LS: begin
                bus.ALUSrcB = 1'b1;
                next_state  = S_MEM;
            end
            S_MEM: begin
                bus.ALUSrcB = 1'b1;
                if (is_ld) begin
                    bus.mRD    = 1'b1;
                    next_state = S_WB_LD;
                end else begin
                    bus.mWR    = is_st;
                    bus.PCWre  = 1'b1;
                    next_state = S_IF;
                end
            end
            S_WB_LD: begin
                bus.DBDataSrc = 1'b1;
                bus.RegWre    = 1'b1;
                bus.PCWre     = 1'b1;
                next_state    = S_IF;
            end
            S_EXE_BR: begin
                bus.ALUOp  = 3'b001;
                bus.PCWre  = 1'b1;
                bus.PCSrc  = br_taken ? 2'b01 : 2'b00;
                next_state = S_IF;
            end
            default: next_state = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IF;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_ID && is_halt)
                halted <= 1'b1;
            if (bus.PCWre)
                instr_count <= instr_count + 1'b1;
        end
    end

    assign bus.state       = state;
    assign bus.nextState   = next_state;
    assign bus.halted      = halted;
    assign bus.instr_count = instr_count;
endmodule
